// File: rtl/ctrl_xfer_if.sv
// Pipeline-side signal bundle of the control-transfer sequencer: ID decode
// inputs, EX resolution operands and the PC/flush/halt controls it returns.
interface ctrl_xfer_if;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        stall_in;
  logic [15:0] ex_rs_val;
  logic [15:0] ex_target;
  logic        jmp_b_sel;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halt_fetch;
  logic        busy;
  logic [15:0] redirect_cnt;

  modport master (
    output id_instr, id_valid, stall_in, ex_rs_val, ex_target,
    input  jmp_b_sel, pc_load, pc_target, flush_if_id, flush_id_ex,
           halt_fetch, busy, redirect_cnt
  );

  modport slave (
    input  id_instr, id_valid, stall_in, ex_rs_val, ex_target,
    output jmp_b_sel, pc_load, pc_target, flush_if_id, flush_id_ex,
           halt_fetch, busy, redirect_cnt
  );
endinterface

// File: rtl/ctrl_xfer_seq.sv
// Control-transfer sequencer: classifies the ID instruction, resolves it in EX
// (predict-not-taken), redirects and flushes on taken, latches HALT, counts redirects.
module ctrl_xfer_seq (
  input logic          clk,
  input logic          rst_n,
  ctrl_xfer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXW    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  // Branch sub-op is the low two opcode bits of the 011xx class.
  typedef enum logic [1:0] {
    BR_EQZ = 2'b00,
    BR_NEZ = 2'b01,
    BR_LTZ = 2'b10,
    BR_GEZ = 2'b11
  } br_op_e;

  state_e      state_q;
  logic        jmp_b_sel_q;
  logic        is_branch_q;
  br_op_e      br_op_q;
  logic [15:0] redirect_cnt_q;

  logic [4:0]  opcode;
  logic        id_branch;
  logic        id_jump;
  logic        id_reg_jump;
  logic        id_halt;
  logic        id_ctrl;
  logic        cond_true;
  logic        taken;
  logic        capture;
  logic        unused_operand_bits;

  assign unused_operand_bits = ^bus.id_instr[10:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opcode      = bus.id_instr[15:11];
    id_branch   = (opcode[4:2] == 3'b011);
    id_jump     = (opcode[4:2] == 3'b001);
    id_reg_jump = id_jump & opcode[0];
    id_halt     = (opcode == 5'b00000);
    id_ctrl     = id_branch | id_jump | id_halt;
  end

  always_comb begin
    cond_true = 1'b0;
    unique case (br_op_q)
      BR_EQZ:  cond_true = (bus.ex_rs_val == 16'h0000);
      BR_NEZ:  cond_true = (bus.ex_rs_val != 16'h0000);
      BR_LTZ:  cond_true = bus.ex_rs_val[15];
      BR_GEZ:  cond_true = ~bus.ex_rs_val[15];
      default: cond_true = 1'b0;
    endcase
  end

  // A taken resolution kills whatever sits in ID, so capture is masked by it.
  assign taken   = (state_q == S_EXW) & (~is_branch_q | cond_true);
  assign capture = bus.id_valid & ~bus.stall_in & ~taken & id_ctrl &
                   (state_q != S_HALTED);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      jmp_b_sel_q    <= 1'b1;
      is_branch_q    <= 1'b0;
      br_op_q        <= BR_EQZ;
      redirect_cnt_q <= 16'h0000;
    end else begin
      unique case (state_q)
        S_IDLE, S_EXW: begin
          if (taken) begin
            state_q <= S_IDLE;
            if (redirect_cnt_q != 16'hFFFF)
              redirect_cnt_q <= redirect_cnt_q + 16'd1;
          end else if (capture) begin
            jmp_b_sel_q <= ~id_reg_jump;
            is_branch_q <= id_branch;
            br_op_q     <= br_op_e'(opcode[1:0]);
            state_q     <= id_halt ? S_HALTED : S_EXW;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.jmp_b_sel    = jmp_b_sel_q;
  assign bus.pc_load      = taken;
  assign bus.pc_target    = bus.ex_target;
  assign bus.flush_if_id  = taken;
  assign bus.flush_id_ex  = taken;
  assign bus.halt_fetch   = (state_q == S_HALTED);
  assign bus.busy         = (state_q == S_EXW);
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_ctrl_xfer_seq.sv
// Bench for ctrl_xfer_seq: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_ctrl_xfer_seq;

  localparam logic [15:0] I_BEQZ = 16'h6000;
  localparam logic [15:0] I_BNEZ = 16'h6800;
  localparam logic [15:0] I_BLTZ = 16'h7000;
  localparam logic [15:0] I_J    = 16'h2000;
  localparam logic [15:0] I_JR   = 16'h2800;
  localparam logic [15:0] I_HALT = 16'h0000;

  logic clk;
  logic rst_n;
  ctrl_xfer_if bus ();

  ctrl_xfer_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: at most one pending control transfer, its opcode, and sticky state.
  bit       m_pend = 0;
  bit [4:0] m_op = '0;
  bit       m_halted = 0;
  bit       m_jbs = 1;
  int       m_cnt = 0;
  int       preload_seq = 0;
  int       seen_seq = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_ctrl(input bit [4:0] op);
    return op inside {5'd0, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};
  endfunction

  function automatic bit resolves_taken(input bit [4:0] op, input logic [15:0] rs);
    case (op)
      5'd12:   return rs == 16'd0;
      5'd13:   return rs != 16'd0;
      5'd14:   return $signed(rs) < 0;
      5'd15:   return $signed(rs) >= 0;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin : model_cmp
    bit       exp_taken;
    bit [4:0] id_op;
    if (preload_seq != seen_seq) begin
      seen_seq = preload_seq;
      m_cnt    = 65533;
    end
    if (!rst_n) begin
      m_pend = 0; m_halted = 0; m_cnt = 0; m_jbs = 1;
    end
    exp_taken = m_pend && resolves_taken(m_op, bus.ex_rs_val);
    check("busy",         {31'd0, bus.busy},        {31'd0, m_pend});
    check("halt_fetch",   {31'd0, bus.halt_fetch},  {31'd0, m_halted});
    check("jmp_b_sel",    {31'd0, bus.jmp_b_sel},   {31'd0, m_jbs});
    check("pc_load",      {31'd0, bus.pc_load},     {31'd0, exp_taken});
    check("flush_if_id",  {31'd0, bus.flush_if_id}, {31'd0, exp_taken});
    check("flush_id_ex",  {31'd0, bus.flush_id_ex}, {31'd0, exp_taken});
    check("redirect_cnt", {16'd0, bus.redirect_cnt}, m_cnt);
    if (exp_taken)
      check("pc_target",  {16'd0, bus.pc_target},   {16'd0, bus.ex_target});
    if (rst_n) begin
      id_op = bus.id_instr[15:11];
      if (exp_taken) begin
        m_pend = 0;
        if (m_cnt < 65535) m_cnt++;
      end else if (!m_halted && bus.id_valid && !bus.stall_in && is_ctrl(id_op)) begin
        m_jbs = !(id_op == 5'd5 || id_op == 5'd7);
        if (id_op == 5'd0) begin
          m_halted = 1; m_pend = 0;
        end else begin
          m_pend = 1; m_op = id_op;
        end
      end else begin
        m_pend = 0;
      end
    end
  end

  // Drive one cycle of inputs just after the edge; return at that cycle's negedge.
  task automatic apply(input logic [15:0] instr, input logic v, input logic s,
                       input logic [15:0] rs, input logic [15:0] tg);
    @(posedge clk);
    #1;
    bus.id_instr  = instr;
    bus.id_valid  = v;
    bus.stall_in  = s;
    bus.ex_rs_val = rs;
    bus.ex_target = tg;
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] rs, input logic [15:0] tg);
    apply(16'h4000, 1'b0, 1'b0, rs, tg);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.id_valid  = 1'b0;
    bus.stall_in  = 1'b0;
    bus.id_instr  = 16'h4000;
    bus.ex_rs_val = 16'h0000;
    bus.ex_target = 16'h0000;
    @(negedge clk);
    check("rst_pc_load",    {31'd0, bus.pc_load},     32'd0);
    check("rst_busy",       {31'd0, bus.busy},        32'd0);
    check("rst_halt_fetch", {31'd0, bus.halt_fetch},  32'd0);
    check("rst_flush",      {30'd0, bus.flush_if_id, bus.flush_id_ex}, 32'd0);
    check("rst_jmp_b_sel",  {31'd0, bus.jmp_b_sel},   32'd1);
    check("rst_cnt",        {16'd0, bus.redirect_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  ops [14] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd4, 5'd5, 5'd6, 5'd7,
                              5'd1, 5'd2, 5'd3, 5'd8, 5'd16, 5'd31};
    logic [15:0] rsv [5]  = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
    logic [15:0] r_instr, r_rs;

    rst_n         = 1'b0;
    bus.id_instr  = 16'h4000;
    bus.id_valid  = 1'b0;
    bus.stall_in  = 1'b0;
    bus.ex_rs_val = 16'h0000;
    bus.ex_target = 16'h0000;
    repeat (2) @(posedge clk);
    do_reset();

    // BEQZ taken
    apply(I_BEQZ, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
    check("beqz_capture_busy", {31'd0, bus.busy}, 32'd0);
    idle(16'h0000, 16'h0040);
    check("beqz_jbs",    {31'd0, bus.jmp_b_sel}, 32'd1);
    check("beqz_load",   {31'd0, bus.pc_load},   32'd1);
    check("beqz_target", {16'd0, bus.pc_target}, 32'h0040);
    check("beqz_flush",  {30'd0, bus.flush_if_id, bus.flush_id_ex}, 32'd3);
    idle(16'h0000, 16'h0000);
    check("beqz_flush_once", {30'd0, bus.flush_if_id, bus.flush_id_ex}, 32'd0);
    check("beqz_cnt",    {16'd0, bus.redirect_cnt}, 32'd1);

    // BLTZ not taken, BNEZ back to back taken
    apply(I_BLTZ, 1'b1, 1'b0, 16'h0000, 16'h0000);
    apply(I_BNEZ, 1'b1, 1'b0, 16'h7FFF, 16'h0F00);
    check("bltz_no_load",  {31'd0, bus.pc_load}, 32'd0);
    check("bltz_no_flush", {30'd0, bus.flush_if_id, bus.flush_id_ex}, 32'd0);
    idle(16'h0001, 16'h0100);
    check("bnez_busy",   {31'd0, bus.busy},      32'd1);
    check("bnez_load",   {31'd0, bus.pc_load},   32'd1);
    check("bnez_target", {16'd0, bus.pc_target}, 32'h0100);
    idle(16'h0000, 16'h0000);
    check("bnez_cnt",    {16'd0, bus.redirect_cnt}, 32'd2);

    // JR
    apply(I_JR, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(16'h5555, 16'h1234);
    check("jr_jbs",    {31'd0, bus.jmp_b_sel}, 32'd0);
    check("jr_load",   {31'd0, bus.pc_load},   32'd1);
    check("jr_target", {16'd0, bus.pc_target}, 32'h1234);

    // J held in ID by a two-cycle stall
    apply(I_J, 1'b1, 1'b1, 16'h0000, 16'h0000);
    check("stall1_busy", {31'd0, bus.busy}, 32'd0);
    apply(I_J, 1'b1, 1'b1, 16'h0000, 16'h0000);
    check("stall2_busy", {31'd0, bus.busy}, 32'd0);
    check("stall2_load", {31'd0, bus.pc_load}, 32'd0);
    apply(I_J, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("release_load", {31'd0, bus.pc_load}, 32'd0);
    idle(16'h0000, 16'h0200);
    check("stall_j_load",   {31'd0, bus.pc_load},   32'd1);
    check("stall_j_target", {16'd0, bus.pc_target}, 32'h0200);
    check("stall_j_jbs",    {31'd0, bus.jmp_b_sel}, 32'd1);

    // Random traffic, model-checked each cycle
    for (int i = 0; i < 1500; i++) begin
      r_instr = 16'($urandom);
      r_instr[15:11] = ops[$urandom_range(0, 13)];
      r_rs = ($urandom_range(0, 2) == 0) ? 16'($urandom) : rsv[$urandom_range(0, 4)];
      apply(r_instr, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
            r_rs, 16'($urandom));
    end

    // Reset while a taken branch waits in EX: no redirect escapes
    apply(I_BEQZ, 1'b1, 1'b0, 16'h0000, 16'h0000);
    do_reset();

    // HALT, then a BEQZ that must be ignored
    apply(I_HALT, 1'b1, 1'b0, 16'h0000, 16'h0000);
    check("halt_not_yet", {31'd0, bus.halt_fetch}, 32'd0);
    apply(I_BEQZ, 1'b1, 1'b0, 16'h0000, 16'h0300);
    check("halt_fetch_1", {31'd0, bus.halt_fetch}, 32'd1);
    check("halt_no_busy", {31'd0, bus.busy},       32'd0);
    apply(I_BEQZ, 1'b1, 1'b0, 16'h0000, 16'h0300);
    check("halt_no_load", {31'd0, bus.pc_load},    32'd0);
    idle(16'h0000, 16'h0300);
    check("halt_fetch_3", {31'd0, bus.halt_fetch}, 32'd1);
    check("halt_cnt",     {16'd0, bus.redirect_cnt}, 32'd0);
    do_reset();

    // Preload the counter near saturation instead of issuing 65533 real jumps
    @(posedge clk);
    #1;
    force dut.redirect_cnt_q = 16'hFFFD;
    preload_seq++;
    #1;
    release dut.redirect_cnt_q;
    @(negedge clk);
    check("preload_cnt", {16'd0, bus.redirect_cnt}, 32'hFFFD);
    for (int k = 0; k < 3; k++) begin
      apply(I_J, 1'b1, 1'b0, 16'h0000, 16'h0000);
      idle(16'h0000, 16'h0400);
      check("sat_load", {31'd0, bus.pc_load}, 32'd1);
    end
    idle(16'h0000, 16'h0000);
    check("sat_cnt", {16'd0, bus.redirect_cnt}, 32'hFFFF);
    apply(I_J, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(16'h0000, 16'h0000);
    idle(16'h0000, 16'h0000);
    check("sat_hold", {16'd0, bus.redirect_cnt}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
